// File: rtl/i2c_slave_core.sv
// Bit-level I2C slave engine: synchronises SCL/SDA, detects START/STOP, matches
// the 7-bit address and shifts data bytes in (write) or out (read).
module i2c_slave_core #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [6:0] address,
    input  logic [7:0] datasend,
    output logic       sended,
    output logic [7:0] datareceive,
    output logic       received,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_RX        = 3'd3,
        ST_RX_ACK    = 3'd4,
        ST_TX        = 3'd5,
        ST_TX_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_r;
    logic [SYNC_STAGES-1:0] sda_sync_r;
    logic                   scl_prev_r;
    logic                   sda_prev_r;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_rise_s;
    logic                   scl_fall_s;
    logic                   start_s;
    logic                   stop_s;
    state_t                 state_r;
    logic [7:0]             shift_r;
    logic [3:0]             bit_cnt_r;
    logic                   rw_r;

    // Pad synchronisers plus one history flop per line for edge detection.
    always_ff @(posedge clk) begin
        if (!reset) begin
            scl_sync_r <= {SYNC_STAGES{1'b1}};
            sda_sync_r <= {SYNC_STAGES{1'b1}};
            scl_prev_r <= 1'b1;
            sda_prev_r <= 1'b1;
        end else begin
            scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl};
            sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_in};
            scl_prev_r <= scl_sync_r[SYNC_STAGES-1];
            sda_prev_r <= sda_sync_r[SYNC_STAGES-1];
        end
    end

    assign scl_s      = scl_sync_r[SYNC_STAGES-1];
    assign sda_s      = sda_sync_r[SYNC_STAGES-1];
    assign scl_rise_s = scl_s & ~scl_prev_r;
    assign scl_fall_s = ~scl_s & scl_prev_r;
    // SCL must be high on both samples so an SCL edge never masquerades as START/STOP.
    assign start_s    = scl_s & scl_prev_r & sda_prev_r & ~sda_s;
    assign stop_s     = scl_s & scl_prev_r & ~sda_prev_r & sda_s;

    // Protocol state machine; START and STOP override every state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            sda_oe      <= 1'b0;
            sended      <= 1'b0;
            received    <= 1'b0;
            busy        <= 1'b0;
            datareceive <= 8'h00;
            shift_r     <= 8'h00;
            bit_cnt_r   <= 4'd0;
            rw_r        <= 1'b0;
        end else if (start_s) begin
            state_r   <= ST_ADDR;
            busy      <= 1'b1;
            bit_cnt_r <= 4'd0;
            sda_oe    <= 1'b0;
            received  <= 1'b0;
            sended    <= 1'b0;
        end else if (stop_s) begin
            state_r   <= ST_IDLE;
            busy      <= 1'b0;
            bit_cnt_r <= 4'd0;
            sda_oe    <= 1'b0;
            received  <= 1'b0;
            sended    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                end
                ST_ADDR: begin
                    if (scl_rise_s) begin
                        shift_r   <= {shift_r[6:0], sda_s};
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                    end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
                        bit_cnt_r <= 4'd0;
                        if (shift_r[7:1] == address) begin
                            state_r <= ST_ADDR_ACK;
                            sda_oe  <= 1'b1;
                            rw_r    <= shift_r[0];
                        end else begin
                            state_r <= ST_WAIT_STOP;
                            sda_oe  <= 1'b0;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall_s) begin
                        bit_cnt_r <= 4'd0;
                        if (rw_r) begin
                            shift_r <= datasend;
                            sda_oe  <= ~datasend[7];
                            state_r <= ST_TX;
                        end else begin
                            sda_oe  <= 1'b0;
                            state_r <= ST_RX;
                        end
                    end
                end
                ST_RX: begin
                    if (scl_rise_s) begin
                        shift_r   <= {shift_r[6:0], sda_s};
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                        received  <= 1'b0;
                    end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
                        sda_oe      <= 1'b1;
                        datareceive <= shift_r;
                        received    <= 1'b1;
                        bit_cnt_r   <= 4'd0;
                        state_r     <= ST_RX_ACK;
                    end
                end
                ST_RX_ACK: begin
                    if (scl_fall_s) begin
                        sda_oe  <= 1'b0;
                        state_r <= ST_RX;
                    end
                end
                ST_TX: begin
                    if (scl_rise_s) begin
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                        sended    <= 1'b0;
                    end else if (scl_fall_s) begin
                        if (bit_cnt_r == 4'd8) begin
                            sda_oe    <= 1'b0;
                            bit_cnt_r <= 4'd0;
                            state_r   <= ST_TX_ACK;
                        end else begin
                            shift_r <= {shift_r[6:0], 1'b0};
                            sda_oe  <= ~shift_r[6];
                        end
                    end
                end
                ST_TX_ACK: begin
                    // A NACK ends the read at the rise, so only an ACK ever reaches the fall.
                    if (scl_rise_s) begin
                        sended <= 1'b1;
                        if (sda_s) begin
                            state_r <= ST_WAIT_STOP;
                        end
                    end else if (scl_fall_s) begin
                        shift_r   <= datasend;
                        sda_oe    <= ~datasend[7];
                        bit_cnt_r <= 4'd0;
                        state_r   <= ST_TX;
                    end
                end
                ST_WAIT_STOP: begin
                    sda_oe <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    sda_oe  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/i2c_slave_core.md
Name: i2c_slave_core

Overview:
- Bit-level I2C slave protocol engine. Sits between the SCL/SDA pads and the register-level slave driver, directly upstream of it.
- Detects START/STOP, matches the 7-bit address, and shifts bytes in and out.
- Hands received bytes to the driver as datareceive/received. Takes bytes to transmit from the driver as datasend, and reports each transmitted byte on sended.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the scl/sda input synchronisers (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 16x the SCL frequency.
- reset  input  1  reset, synchronous, active-low.
- scl  input  1  raw SCL pad input.
- sda_in  input  1  raw SDA pad input.
- sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
- address  input  7  own slave address, sampled at the address-byte compare.
- datasend  input  8  byte to transmit, sampled at the TX load point.
- sended  output  1  level flag: a TX byte has completed.
- datareceive  output  8  last received data byte (the address byte is never presented here).
- received  output  1  level flag: datareceive holds a new byte.
- busy  output  1  1 between START and STOP.

Behaviour:
Reset (reset=0 at a clk edge):
- State = IDLE; sda_oe=0; sended=0; received=0; busy=0; datareceive=8'h00.
- Shift register and bit counter are cleared.
- Synchronisers reset to 1.
- Reset mid-transfer releases SDA on the next clk edge.

Input sampling:
- scl and sda each pass through SYNC_STAGES flops, then one history flop for edge detection.
- Event latency is SYNC_STAGES+1 clk from the pad edge.

Bus events (evaluated on synchronised signals):
- START: sda falls while scl=1.
- STOP: sda rises while scl=1.
- START takes priority over every state, including a repeated START. It sets busy=1, clears the bit counter and goes to ADDR.
- STOP goes to IDLE from any state, with busy=0 and sda_oe=0.

State machine (all states advance on SCL edges):
- IDLE: wait for START.
- ADDR:
  - Shift sda in MSB-first on each SCL rise; 8 bits.
  - On the 8th SCL fall: if bits[7:1]==address, go to ADDR_ACK with sda_oe=1 and latch rw=bit0.
  - Otherwise go to WAIT_STOP with sda_oe=0.
- ADDR_ACK: on SCL fall, release SDA. If rw=0 go to RX. If rw=1, load the shifter from datasend, drive sda_oe=~datasend[7], and go to TX.
- RX:
  - Shift 8 bits.
  - On the 8th SCL fall: sda_oe=1 (ACK every data byte), datareceive<=shifter, received<=1, go to RX_ACK.
- RX_ACK: on SCL fall, sda_oe=0, go to RX.
- TX:
  - On each SCL fall, shift and drive sda_oe=~next bit.
  - After the 8th bit's SCL fall, release SDA and go to TX_ACK.
- TX_ACK:
  - On SCL rise, sample the master's ACK and set sended<=1.
  - ACK (sda=0): on SCL fall, reload from datasend, drive bit7 and go to TX.
  - NACK: go to WAIT_STOP.
- WAIT_STOP: SDA released; wait for STOP or START.

Handshake flags:
- received and sended stay high until the first SCL rise of the next byte, or until START, STOP or reset, whichever comes first.
- Each flag is therefore a clean 0→1→0 pulse at least several clk wide.
- received and sended are never high together.

Timing rules:
- SDA changes only 1 clk after a detected SCL fall. This provides hold time.
- datasend must be stable from the assertion of received/sended up to the TX load point.

Boundaries:
- A START inside a byte aborts that byte without asserting any flag.
- STOP during ADDR_ACK or RX_ACK releases SDA immediately.
- More than 8 bits without an ACK slot is not possible, because the bit counter wraps only through the ACK states.
- General-call address 7'h00 is not acknowledged unless address==7'h00.

Test Plan:
- Write: address=7'h3C; master sends START, 0x78, 0xD0, STOP → ACK on both bytes; datareceive=8'hD0; received goes 0→1→0 exactly once; busy returns to 0 after STOP.
- Read: datasend=8'h58; master sends START, 0x79, clocks 8 bits, NACK, STOP → SDA bits equal 0101_1000; sended pulses once; state ends in IDLE.
- Address mismatch: master sends START, 0x7A, 0x55, STOP → sda_oe stays 0 throughout; received never asserts.
- Repeated-start register read: master sends START, 0x78, 0xD0, Sr, 0x79; driver sets datasend=8'h58 after received; master reads 1 byte with NACK → bus returns 0x58; exactly one received pulse and one sended pulse.
- Multi-byte read with ACK: datasend updated from 0x34 to 0x12 after the first sended → bus returns 0x34 then 0x12; two sended pulses.
- reset=0 asserted while the core drives ACK low → sda_oe=0 on the next clk; all flags are 0; after release, the core ignores the bus until the next START.
